// File: rtl/scene_pkg.sv
// Shared types and constants for the scene sequencer.
//   scene_state_t : top-level game phase, encoded as seen on scene_state
//   lane_t        : head lane position
//   OFS_W         : width of every layer offset (two's complement)
//   DEF_*         : default values for the scene_sequencer parameters
//   slew_toward   : one bounded step of a value toward a target
package scene_pkg;

  localparam int unsigned OFS_W = 12;

  typedef enum logic [1:0] {
    COUNTDOWN = 2'd0,
    LOGO      = 2'd1,
    SLIDE     = 2'd2,
    RUN       = 2'd3
  } scene_state_t;

  typedef enum logic [1:0] {
    LEFT   = 2'd0,
    CENTER = 2'd1,
    RIGHT  = 2'd2
  } lane_t;

  localparam int unsigned DEF_COUNTDOWN_INIT = 50;
  localparam int          DEF_LOGO_STEP      = 30;
  localparam int          DEF_LOGO_END       = -600;
  localparam int          DEF_HEAD_START     = -170;
  localparam int          DEF_HEAD_STEP      = 17;
  localparam int          DEF_LANE_OFFSET    = 100;
  localparam int          DEF_LANE_STEP      = 25;
  localparam int unsigned DEF_COIN_FRAMES    = 60;
  localparam int          DEF_COIN_H0        = -200;
  localparam int          DEF_COIN_V0        = -40;
  localparam int          DEF_COIN_DV        = 6;

  // Move cur by at most step toward tgt, landing exactly on tgt when closer than step.
  // The difference is taken one bit wider so opposite-sign operands cannot wrap.
  function automatic logic signed [OFS_W-1:0] slew_toward(
    input logic signed [OFS_W-1:0] cur,
    input logic signed [OFS_W-1:0] tgt,
    input logic signed [OFS_W-1:0] step
  );
    logic signed [OFS_W:0] diff;
    logic signed [OFS_W:0] mag;
    diff = $signed({tgt[OFS_W-1], tgt}) - $signed({cur[OFS_W-1], cur});
    mag  = $signed({step[OFS_W-1], step});
    if (diff > mag) begin
      return cur + step;
    end else if (diff < -mag) begin
      return cur - step;
    end else begin
      return tgt;
    end
  endfunction

endpackage

// File: rtl/scene_sequencer_if.sv
// Bundle between the scene sequencer and its surroundings.
//   vsync, btn_left, btn_right  : inputs to the sequencer (timing generator, buttons)
//   frame_tick                  : one-cycle pulse per vsync rising edge
//   scene_state                 : 0=COUNTDOWN 1=LOGO 2=SLIDE 3=RUN
//   *_hoffset / *_voffset       : signed layer offsets
//   coin_visible                : coin layer alpha gate
// slave is the sequencer side, master the driving/observing side.
interface scene_sequencer_if;
  import scene_pkg::*;

  logic                    vsync;
  logic                    btn_left;
  logic                    btn_right;
  logic                    frame_tick;
  logic [1:0]              scene_state;
  logic signed [OFS_W-1:0] logo_voffset;
  logic signed [OFS_W-1:0] head_hoffset;
  logic signed [OFS_W-1:0] head_voffset;
  logic signed [OFS_W-1:0] coin_hoffset;
  logic signed [OFS_W-1:0] coin_voffset;
  logic                    coin_visible;

  modport slave (
    input  vsync, btn_left, btn_right,
    output frame_tick, scene_state, logo_voffset, head_hoffset, head_voffset,
           coin_hoffset, coin_voffset, coin_visible
  );

  modport master (
    output vsync, btn_left, btn_right,
    input  frame_tick, scene_state, logo_voffset, head_hoffset, head_voffset,
           coin_hoffset, coin_voffset, coin_visible
  );

endinterface

// File: rtl/scene_sequencer_button_edge.sv
// Raw button conditioner: two-flop synchronizer followed by a rising-edge detector.
//   CLK100MHZ  : clock
//   CPU_RESETN : synchronous active-low reset
//   btn        : asynchronous raw button
//   rise       : one-cycle pulse per 0->1 transition of the synchronized button
module button_edge (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/scene_sequencer.sv
// Frame-rate scene controller. Detects vsync rising edges and, once per frame, steps the
// intro sequence (countdown, logo scroll-out, head slide-in) and then run mode (lane changes
// from the buttons, cyclic coin trajectory). Drives the layer offsets.
//   CLK100MHZ  : the only clock
//   CPU_RESETN : synchronous active-low reset
//   bus        : vsync/button inputs, frame_tick, scene_state, layer offsets, coin_visible
// Every output comes straight from a register.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int unsigned COUNTDOWN_INIT = DEF_COUNTDOWN_INIT,
  parameter int          LOGO_STEP      = DEF_LOGO_STEP,
  parameter int          LOGO_END       = DEF_LOGO_END,
  parameter int          HEAD_START     = DEF_HEAD_START,
  parameter int          HEAD_STEP      = DEF_HEAD_STEP,
  parameter int          LANE_OFFSET    = DEF_LANE_OFFSET,
  parameter int          LANE_STEP      = DEF_LANE_STEP,
  parameter int unsigned COIN_FRAMES    = DEF_COIN_FRAMES,
  parameter int          COIN_H0        = DEF_COIN_H0,
  parameter int          COIN_V0        = DEF_COIN_V0,
  parameter int          COIN_DV        = DEF_COIN_DV
) (
  input logic              CLK100MHZ,
  input logic              CPU_RESETN,
  scene_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = ($clog2(COUNTDOWN_INIT + 1) > 0) ?
                                  $clog2(COUNTDOWN_INIT + 1) : 1;
  localparam int unsigned PH_W  = ($clog2(COIN_FRAMES) > 0) ? $clog2(COIN_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(COUNTDOWN_INIT);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(COIN_FRAMES - 1);

  localparam logic signed [OFS_W-1:0] LOGO_STEP_S   = OFS_W'(LOGO_STEP);
  localparam logic signed [OFS_W-1:0] LOGO_END_S    = OFS_W'(LOGO_END);
  localparam logic signed [OFS_W-1:0] HEAD_START_S  = OFS_W'(HEAD_START);
  localparam logic signed [OFS_W-1:0] HEAD_STEP_S   = OFS_W'(HEAD_STEP);
  localparam logic signed [OFS_W-1:0] LANE_OFFSET_S = OFS_W'(LANE_OFFSET);
  localparam logic signed [OFS_W-1:0] LANE_STEP_S   = OFS_W'(LANE_STEP);
  localparam logic signed [OFS_W-1:0] COIN_H0_S     = OFS_W'(COIN_H0);
  localparam logic signed [OFS_W-1:0] COIN_V0_S     = OFS_W'(COIN_V0);
  localparam logic signed [OFS_W-1:0] COIN_DV_S     = OFS_W'(COIN_DV);

  // Frame tick detection
  logic vs_q;
  logic tick;
  logic frame_tick_q;

  // vs_q resets high so a vsync already high at reset release is not a tick.
  assign tick = bus.vsync & ~vs_q;

  // Button edges
  logic edge_l;
  logic edge_r;

  button_edge u_btn_left (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .btn        (bus.btn_left),
    .rise       (edge_l)
  );

  button_edge u_btn_right (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .btn        (bus.btn_right),
    .rise       (edge_r)
  );

  // Scene FSM
  scene_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Datapath
  logic signed [OFS_W-1:0] logo_q, logo_d;
  logic signed [OFS_W-1:0] head_v_q, head_v_d;
  logic signed [OFS_W-1:0] head_h_q, head_h_d;
  lane_t                   lane_q, lane_d;
  logic                    pend_l_q, pend_l_d;
  logic                    pend_r_q, pend_r_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [OFS_W-1:0] coin_h_q, coin_h_d;
  logic signed [OFS_W-1:0] coin_v_q, coin_v_d;
  logic                    vis_q, vis_d;

  logic signed [OFS_W-1:0] logo_step;
  logic signed [OFS_W-1:0] head_step;
  logic signed [OFS_W-1:0] lane_tgt;
  logic signed [OFS_W-1:0] ph_ext;

  assign logo_step = logo_q - LOGO_STEP_S;
  assign head_step = head_v_q + HEAD_STEP_S;

  // State register
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q <= COUNTDOWN;
      cnt_q   <= CNT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      unique case (state_q)
        COUNTDOWN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = LOGO;
          end
        end
        LOGO: begin
          if (logo_step <= LOGO_END_S) state_d = SLIDE;
        end
        SLIDE: begin
          if (!head_step[OFS_W-1]) state_d = RUN;
        end
        RUN: begin
          state_d = RUN;
        end
        default: state_d = COUNTDOWN;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    logo_d   = logo_q;
    head_v_d = head_v_q;
    head_h_d = head_h_q;
    lane_d   = lane_q;
    phase_d  = phase_q;
    lane_tgt = '0;

    // Requests only accumulate in RUN. On a tick the old flags are consumed and an edge on
    // that same clock becomes the only pending request for the next tick.
    if (state_q == RUN) begin
      if (tick) begin
        pend_l_d = edge_l;
        pend_r_d = edge_r;
      end else begin
        pend_l_d = pend_l_q | edge_l;
        pend_r_d = pend_r_q | edge_r;
      end
    end else begin
      pend_l_d = 1'b0;
      pend_r_d = 1'b0;
    end

    if (tick) begin
      unique case (state_q)
        LOGO: begin
          logo_d = (logo_step <= LOGO_END_S) ? LOGO_END_S : logo_step;
        end
        SLIDE: begin
          head_v_d = head_step[OFS_W-1] ? head_step : '0;
        end
        RUN: begin
          if (pend_l_q && !pend_r_q) begin
            lane_d = (lane_q == RIGHT) ? CENTER : LEFT;
          end else if (pend_r_q && !pend_l_q) begin
            lane_d = (lane_q == LEFT) ? CENTER : RIGHT;
          end
          unique case (lane_d)
            LEFT:    lane_tgt = LANE_OFFSET_S;
            RIGHT:   lane_tgt = -LANE_OFFSET_S;
            default: lane_tgt = '0;
          endcase
          head_h_d = slew_toward(head_h_q, lane_tgt, LANE_STEP_S);
          phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        end
        default: ;
      endcase
    end

    ph_ext   = signed'(OFS_W'(phase_d));
    coin_h_d = COIN_H0_S + ph_ext;
    coin_v_d = COIN_V0_S - COIN_DV_S * ph_ext;
    vis_d    = (state_d == RUN);
  end

  // Datapath registers
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      vs_q         <= 1'b1;
      frame_tick_q <= 1'b0;
      logo_q       <= '0;
      head_v_q     <= HEAD_START_S;
      head_h_q     <= '0;
      lane_q       <= CENTER;
      pend_l_q     <= 1'b0;
      pend_r_q     <= 1'b0;
      phase_q      <= '0;
      coin_h_q     <= COIN_H0_S;
      coin_v_q     <= COIN_V0_S;
      vis_q        <= 1'b0;
    end else begin
      vs_q         <= bus.vsync;
      frame_tick_q <= tick;
      logo_q       <= logo_d;
      head_v_q     <= head_v_d;
      head_h_q     <= head_h_d;
      lane_q       <= lane_d;
      pend_l_q     <= pend_l_d;
      pend_r_q     <= pend_r_d;
      phase_q      <= phase_d;
      coin_h_q     <= coin_h_d;
      coin_v_q     <= coin_v_d;
      vis_q        <= vis_d;
    end
  end

  assign bus.frame_tick   = frame_tick_q;
  assign bus.scene_state  = state_q;
  assign bus.logo_voffset = logo_q;
  assign bus.head_voffset = head_v_q;
  assign bus.head_hoffset = head_h_q;
  assign bus.coin_hoffset = coin_h_q;
  assign bus.coin_voffset = coin_v_q;
  assign bus.coin_visible = vis_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer with COUNTDOWN_INIT=3 and default offsets.
// A frame-level reference model (integers, one update per vsync tick) predicts outputs.
module tb_scene_sequencer;

  localparam int CD_INIT     = 3;
  localparam int LOGO_STEP   = 30;
  localparam int LOGO_END    = -600;
  localparam int HEAD_START  = -170;
  localparam int HEAD_STEP   = 17;
  localparam int LANE_OFFSET = 100;
  localparam int LANE_STEP   = 25;
  localparam int COIN_FRAMES = 60;
  localparam int COIN_H0     = -200;
  localparam int COIN_V0     = -40;
  localparam int COIN_DV     = 6;

  logic clk = 1'b0;
  logic rstn;

  scene_sequencer_if bus_if ();

  scene_sequencer #(
    .COUNTDOWN_INIT (CD_INIT)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rstn),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: state 0..3, lane -1=right 0=center +1=left
  int m_state, m_cnt, m_logo, m_headv, m_headh, m_lane, m_phase;
  bit m_pl, m_pr;

  task automatic model_reset();
    m_state = 0; m_cnt = CD_INIT; m_logo = 0; m_headv = HEAD_START;
    m_headh = 0; m_lane = 0; m_phase = 0; m_pl = 0; m_pr = 0;
  endtask

  task automatic model_tick();
    int tgt;
    case (m_state)
      0: if (m_cnt != 0) m_cnt--; else m_state = 1;
      1: begin
        m_logo -= LOGO_STEP;
        if (m_logo <= LOGO_END) begin m_logo = LOGO_END; m_state = 2; end
      end
      2: begin
        m_headv += HEAD_STEP;
        if (m_headv >= 0) begin m_headv = 0; m_state = 3; end
      end
      default: begin
        if (m_pl && !m_pr && m_lane < 1) m_lane++;
        else if (m_pr && !m_pl && m_lane > -1) m_lane--;
        m_pl = 0; m_pr = 0;
        tgt = m_lane * LANE_OFFSET;
        if (m_headh < tgt) m_headh = (m_headh + LANE_STEP > tgt) ? tgt : m_headh + LANE_STEP;
        else if (m_headh > tgt) m_headh = (m_headh - LANE_STEP < tgt) ? tgt : m_headh - LANE_STEP;
        m_phase = (m_phase + 1) % COIN_FRAMES;
      end
    endcase
  endtask

  // One vsync rising edge; returns 1 time unit after the tick edge.
  task automatic frame();
    repeat (6) @(posedge clk);
    #1 bus_if.vsync = 1'b1;
    @(posedge clk);
    #1 bus_if.vsync = 1'b0;
    model_tick();
  endtask

  // Pulse buttons for 3 cycles, well clear of any tick, and let the edge settle.
  task automatic press(input bit l, input bit r);
    @(posedge clk);
    #1 bus_if.btn_left = l; bus_if.btn_right = r;
    repeat (3) @(posedge clk);
    #1 bus_if.btn_left = 1'b0; bus_if.btn_right = 1'b0;
    repeat (4) @(posedge clk);
    if (m_state == 3) begin
      if (l) m_pl = 1;
      if (r) m_pr = 1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus_if.vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_if.scene_state !== 2'd0) begin errors++;
      $display("FAIL reset_state: got %0d expected 0", bus_if.scene_state); end
    checks++; if (bus_if.logo_voffset !== 12'sd0 || bus_if.head_voffset !== 12'(HEAD_START)
                  || bus_if.head_hoffset !== 12'sd0) begin errors++;
      $display("FAIL reset_offsets: got logo=%0d headv=%0d headh=%0d expected 0 %0d 0",
               bus_if.logo_voffset, bus_if.head_voffset, bus_if.head_hoffset, HEAD_START); end
    checks++; if (bus_if.coin_hoffset !== 12'(COIN_H0) || bus_if.coin_voffset !== 12'(COIN_V0)
                  || bus_if.coin_visible !== 1'b0 || bus_if.frame_tick !== 1'b0) begin errors++;
      $display("FAIL reset_coin: got h=%0d v=%0d vis=%0b tick=%0b expected %0d %0d 0 0",
               bus_if.coin_hoffset, bus_if.coin_voffset, bus_if.coin_visible,
               bus_if.frame_tick, COIN_H0, COIN_V0); end
    rstn = 1'b1;
    // vsync already high at release must not tick
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (bus_if.frame_tick !== 1'b0) begin errors++;
        $display("FAIL release_no_tick cyc %0d: got %0b expected 0", i, bus_if.frame_tick); end
    end
    bus_if.vsync = 1'b0;
    model_reset();
  endtask

  task automatic test_intro();
    for (int t = 1; t <= CD_INIT + 1 + 20 + 10; t++) begin
      frame();
      checks++; if (bus_if.frame_tick !== 1'b1) begin errors++;
        $display("FAIL intro_tick t%0d: got %0b expected 1", t, bus_if.frame_tick); end
      checks++; if (bus_if.scene_state !== m_state[1:0] || bus_if.logo_voffset !== 12'(m_logo)
                    || bus_if.head_voffset !== 12'(m_headv)) begin errors++;
        $display("FAIL intro t%0d: got st=%0d logo=%0d headv=%0d expected %0d %0d %0d", t,
                 bus_if.scene_state, bus_if.logo_voffset, bus_if.head_voffset,
                 m_state, m_logo, m_headv); end
      checks++; if (bus_if.coin_visible !== (m_state == 3)) begin errors++;
        $display("FAIL intro_vis t%0d: got %0b expected %0b", t, bus_if.coin_visible,
                 m_state == 3); end
      if (t == CD_INIT + 1) begin
        checks++; if (bus_if.scene_state !== 2'd1) begin errors++;
          $display("FAIL logo_entry: got %0d expected 1", bus_if.scene_state); end
      end
      if (t == CD_INIT + 1 + 20) begin
        checks++; if (bus_if.scene_state !== 2'd2 || bus_if.logo_voffset !== -12'sd600) begin
          errors++; $display("FAIL slide_entry: got st=%0d logo=%0d expected 2 -600",
                             bus_if.scene_state, bus_if.logo_voffset); end
      end
    end
    @(posedge clk); #1;
    checks++; if (bus_if.frame_tick !== 1'b0) begin errors++;
      $display("FAIL tick_width: got %0b expected 0", bus_if.frame_tick); end
    checks++; if (bus_if.scene_state !== 2'd3 || bus_if.head_voffset !== 12'sd0
                  || bus_if.coin_visible !== 1'b1) begin errors++;
      $display("FAIL run_entry: got st=%0d headv=%0d vis=%0b expected 3 0 1",
               bus_if.scene_state, bus_if.head_voffset, bus_if.coin_visible); end
  endtask

  task automatic test_lane();
    press(1, 0);
    for (int i = 1; i <= 4; i++) begin
      frame();
      checks++; if (bus_if.head_hoffset !== 12'(25 * i) || bus_if.head_hoffset !== 12'(m_headh))
      begin errors++;
        $display("FAIL lane_left step %0d: got %0d expected %0d", i, bus_if.head_hoffset,
                 25 * i); end
    end
    press(1, 0);
    repeat (2) begin
      frame();
      checks++; if (bus_if.head_hoffset !== 12'sd100) begin errors++;
        $display("FAIL lane_left_sat: got %0d expected 100", bus_if.head_hoffset); end
    end
    press(0, 1);
    frame();
    press(0, 1);
    for (int i = 0; i < 8; i++) begin
      frame();
      checks++; if (bus_if.head_hoffset !== 12'(m_headh)) begin errors++;
        $display("FAIL lane_right frame %0d: got %0d expected %0d", i, bus_if.head_hoffset,
                 m_headh); end
    end
    checks++; if (bus_if.head_hoffset !== -12'sd100) begin errors++;
      $display("FAIL lane_right_end: got %0d expected -100", bus_if.head_hoffset); end
  endtask

  task automatic test_both();
    press(1, 1);
    repeat (2) begin
      frame();
      checks++; if (bus_if.head_hoffset !== -12'sd100) begin errors++;
        $display("FAIL both_same: got %0d expected -100", bus_if.head_hoffset); end
    end
    press(1, 0);
    press(0, 1);
    repeat (2) begin
      frame();
      checks++; if (bus_if.head_hoffset !== -12'sd100) begin errors++;
        $display("FAIL both_split: got %0d expected -100", bus_if.head_hoffset); end
    end
  endtask

  task automatic test_hold();
    @(posedge clk);
    #1 bus_if.btn_left = 1'b1;
    repeat (6) @(posedge clk);
    if (m_state == 3) m_pl = 1;
    for (int i = 0; i < 5; i++) begin
      frame();
      checks++; if (bus_if.head_hoffset !== 12'(m_headh)) begin errors++;
        $display("FAIL hold frame %0d: got %0d expected %0d", i, bus_if.head_hoffset,
                 m_headh); end
    end
    bus_if.btn_left = 1'b0;
    checks++; if (bus_if.head_hoffset !== 12'sd0) begin errors++;
      $display("FAIL hold_one_step: got %0d expected 0", bus_if.head_hoffset); end
  endtask

  task automatic test_coin();
    for (int i = 0; i < 2 * COIN_FRAMES && m_phase != COIN_FRAMES - 1; i++) begin
      frame();
      checks++; if (bus_if.coin_hoffset !== 12'(COIN_H0 + m_phase)
                    || bus_if.coin_voffset !== 12'(COIN_V0 - COIN_DV * m_phase)) begin errors++;
        $display("FAIL coin phase %0d: got %0d/%0d expected %0d/%0d", m_phase,
                 bus_if.coin_hoffset, bus_if.coin_voffset, COIN_H0 + m_phase,
                 COIN_V0 - COIN_DV * m_phase); end
    end
    checks++; if (bus_if.coin_hoffset !== -12'sd141 || bus_if.coin_voffset !== -12'sd394) begin
      errors++; $display("FAIL coin_last: got %0d/%0d expected -141/-394",
                         bus_if.coin_hoffset, bus_if.coin_voffset); end
    frame();
    checks++; if (bus_if.coin_hoffset !== -12'sd200 || bus_if.coin_voffset !== -12'sd40) begin
      errors++; $display("FAIL coin_wrap: got %0d/%0d expected -200/-40",
                         bus_if.coin_hoffset, bus_if.coin_voffset); end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 4));
      if (r == 1) press(1, 0);
      else if (r == 2) press(0, 1);
      else if (r == 3) press(1, 1);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      frame();
      checks++; if (bus_if.head_hoffset !== 12'(m_headh) || bus_if.scene_state !== 2'd3
                    || bus_if.coin_hoffset !== 12'(COIN_H0 + m_phase)
                    || bus_if.coin_voffset !== 12'(COIN_V0 - COIN_DV * m_phase)) begin errors++;
        $display("FAIL random %0d: got hh=%0d st=%0d coin=%0d/%0d expected %0d 3 %0d/%0d", i,
                 bus_if.head_hoffset, bus_if.scene_state, bus_if.coin_hoffset,
                 bus_if.coin_voffset, m_headh, COIN_H0 + m_phase,
                 COIN_V0 - COIN_DV * m_phase); end
    end
  endtask

  task automatic test_reset_midrun();
    press(1, 0); frame();
    press(1, 0); frame();
    for (int i = 0; i < 2 * COIN_FRAMES && m_phase != 30; i++) frame();
    repeat (4) frame();
    for (int i = 0; i < 2 * COIN_FRAMES && m_phase != 30; i++) frame();
    checks++; if (bus_if.coin_hoffset !== -12'sd170 || bus_if.head_hoffset !== 12'sd100) begin
      errors++; $display("FAIL pre_reset: got coinh=%0d headh=%0d expected -170 100",
                         bus_if.coin_hoffset, bus_if.head_hoffset); end
    repeat (6) @(posedge clk);
    #1 bus_if.vsync = 1'b1; rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    checks++; if (bus_if.scene_state !== 2'd0 || bus_if.coin_visible !== 1'b0
                  || bus_if.frame_tick !== 1'b0) begin errors++;
      $display("FAIL midrun_reset_ctl: got st=%0d vis=%0b tick=%0b expected 0 0 0",
               bus_if.scene_state, bus_if.coin_visible, bus_if.frame_tick); end
    checks++; if (bus_if.logo_voffset !== 12'sd0 || bus_if.head_voffset !== 12'(HEAD_START)
                  || bus_if.head_hoffset !== 12'sd0 || bus_if.coin_hoffset !== 12'(COIN_H0)
                  || bus_if.coin_voffset !== 12'(COIN_V0)) begin errors++;
      $display("FAIL midrun_reset_ofs: got %0d %0d %0d %0d %0d expected 0 %0d 0 %0d %0d",
               bus_if.logo_voffset, bus_if.head_voffset, bus_if.head_hoffset,
               bus_if.coin_hoffset, bus_if.coin_voffset, HEAD_START, COIN_H0, COIN_V0); end
    @(posedge clk); #1 bus_if.vsync = 1'b0;
  endtask

  task automatic test_early_buttons();
    for (int i = 0; i < 60 && m_state != 3; i++) begin
      press(1, 0);
      frame();
    end
    checks++; if (bus_if.scene_state !== 2'd3) begin errors++;
      $display("FAIL early_reach_run: got %0d expected 3", bus_if.scene_state); end
    repeat (3) begin
      frame();
      checks++; if (bus_if.head_hoffset !== 12'sd0 || bus_if.head_hoffset !== 12'(m_headh))
      begin errors++;
        $display("FAIL early_discard: got %0d expected 0", bus_if.head_hoffset); end
    end
  endtask

  initial begin
    bus_if.vsync = 1'b0;
    bus_if.btn_left = 1'b0;
    bus_if.btn_right = 1'b0;
    rstn = 1'b0;
    model_reset();
    test_reset();
    test_intro();
    test_lane();
    test_both();
    test_hold();
    test_coin();
    test_random();
    test_reset_midrun();
    test_early_buttons();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Frame-rate game controller that sequences the sprite/layer compositing chain (background, logo, head, coin layers) between the VGA timing generator and the layers.
- Replaces ad-hoc per-frame offset logic clocked on vsync with a single-clock FSM: intro countdown, logo scroll-out, head slide-in, then run mode.
- In run mode it handles lane changes from the buttons and the cyclic coin trajectory.
- Drives the hoffset/voffset inputs of each layer instance.

Parameters:
- COUNTDOWN_INIT, 50, frame ticks spent in COUNTDOWN before the logo scroll starts.
- LOGO_STEP, 30, logo voffset decrement per tick.
- LOGO_END, -600, final logo voffset (clamp value).
- HEAD_START, -170, head voffset at reset.
- HEAD_STEP, 17, head voffset increment per tick during SLIDE.
- LANE_OFFSET, 100, head hoffset magnitude for the left/right lanes (left = +, right = -).
- LANE_STEP, 25, head hoffset slew per tick toward the lane target.
- COIN_FRAMES, 60, coin trajectory length in ticks.
- COIN_H0, -200, coin hoffset at phase 0.
- COIN_V0, -40, coin voffset at phase 0.
- COIN_DV, 6, coin voffset decrement per phase.

Ports:
- CLK100MHZ  in  1  system clock; the only clock.
- CPU_RESETN  in  1  reset, synchronous, active-low.
- vsync  in  1  VGA vsync from the timing generator; sampled on CLK100MHZ.
- btn_left  in  1  raw left button.
- btn_right  in  1  raw right button.
- frame_tick  out  1  one-cycle pulse per vsync rising edge.
- scene_state  out  2  0=COUNTDOWN, 1=LOGO, 2=SLIDE, 3=RUN.
- logo_voffset  out  12 signed  logo layer voffset.
- head_hoffset  out  12 signed  head layer hoffset.
- head_voffset  out  12 signed  head layer voffset.
- coin_hoffset  out  12 signed  coin layer hoffset.
- coin_voffset  out  12 signed  coin layer voffset.
- coin_visible  out  1  high only in RUN; gates the coin layer alpha.

Behaviour:
- Clocking and reset: everything is clocked on CLK100MHZ. Reset is synchronous: CPU_RESETN low at any edge forces reset values and overrides a simultaneous tick.
- Reset values: state COUNTDOWN, countdown counter=COUNTDOWN_INIT, logo_voffset=0, head_voffset=HEAD_START, head_hoffset=0, lane=CENTER, pending requests cleared, coin phase=0, coin_hoffset=COIN_H0, coin_voffset=COIN_V0, coin_visible=0, frame_tick=0, vs_q=1 (so vsync already high at reset release gives no tick).
- Tick: vs_q registers vsync. At edge E with vsync=1 and vs_q=0, frame_tick is 1 for the following cycle, and all frame-driven registers update at that same edge E. All outputs are registered; there is no combinational path from inputs to outputs.
- COUNTDOWN, on each tick:
  - counter≠0: decrement.
  - counter=0: go to LOGO.
  - Total COUNTDOWN_INIT+1 ticks.
- LOGO, on each tick: logo_voffset -= LOGO_STEP. If the result ≤ LOGO_END, clamp to LOGO_END and enter SLIDE on the same tick. Defaults give 20 ticks.
- SLIDE, on each tick: head_voffset += HEAD_STEP, saturating at 0. On reaching 0, enter RUN. Defaults give 10 ticks.
- RUN: terminal state; only reset exits it. logo_voffset and head_voffset are held.
- Buttons:
  - Each button passes through a 2-flop synchronizer plus rising-edge detect.
  - An edge while in RUN sets that direction's pending flag.
  - Edges outside RUN are discarded. A held button yields one edge only.
- Lane update, at each RUN tick:
  - Left pending only: lane moves one step toward LEFT, saturating.
  - Right pending only: lane moves one step toward RIGHT, saturating.
  - Both pending: no move.
  - Both flags are cleared at every tick. A button edge arriving on the same edge as a tick is kept for the next tick.
- Lane target: LEFT=+LANE_OFFSET, CENTER=0, RIGHT=-LANE_OFFSET.
- Head slew: each RUN tick, head_hoffset moves toward the target by LANE_STEP, clamped to the target. The target may change mid-slew; the slew then heads to the new target.
- Coin:
  - Each RUN tick, phase = (phase==COIN_FRAMES-1) ? 0 : phase+1.
  - coin_hoffset = COIN_H0 + phase; coin_voffset = COIN_V0 - COIN_DV*phase. Compute in 12-bit signed; for the defaults the maximum magnitude is 394, so no overflow.
  - Outside RUN, phase is held at 0.
  - coin_visible = (state==RUN), registered.

Decomposition:
- Shared package scene_pkg:
  - scene_state_t enum (COUNTDOWN, LOGO, SLIDE, RUN).
  - lane_t enum (LEFT, CENTER, RIGHT).
  - Offset width constant OFS_W=12.
  - Default parameter constants.
- Sub-module button_edge: synchronizer plus rising-edge detector with synchronous active-low reset. Instantiated twice.

Test Plan:
- Reset then sequence, COUNTDOWN_INIT=3 with periodic vsync pulses:
  - Ticks 1-3: state stays 0. Tick 4: state=1.
  - logo_voffset steps 0,-30,…; reaches -600 on the 20th LOGO tick, together with state=2.
  - head_voffset steps -170,-153,…,0 over 10 ticks; then state=3 and coin_visible=1.
- Lane change in RUN:
  - One btn_left pulse: head_hoffset 25,50,75,100 on successive ticks.
  - Second btn_left: stays 100.
  - btn_right ×2: slews to -100.
- btn_left and btn_right pulsed between the same two ticks → lane unchanged, head_hoffset constant. Button held high for 5 frames → exactly one lane step.
- Coin wrap:
  - After 59 RUN ticks: coin_hoffset=-141, coin_voffset=-394.
  - Next tick: -200 / -40.
- Reset mid-RUN (lane LEFT, phase 30): CPU_RESETN low for 1 cycle, coincident with a vsync edge → next cycle shows all reset values, state=0, coin_visible=0, frame_tick=0.
- btn_left pulses during COUNTDOWN and LOGO → after reaching RUN, lane is CENTER and head_hoffset=0.
